sha256_compress_ctrl: RTL

SHA256_COMPRESS_CTRL -- requirements
Module: sha256_compress_ctrl

---
 rtl/sha256_pkg.sv | 82 ++++++++
 rtl/sha256_msg_sched.sv | 30 +++
 rtl/sha256_roundfnc.sv | 32 +++
 rtl/sha256_compress_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared constants, FSM state type and word-level helper functions.
package sha256_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned DIGEST_W = 256;
  localparam int unsigned ROUNDS   = 64;
  localparam int unsigned T_W      = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
    logic [WORD_W-1:0] e;
    logic [WORD_W-1:0] f;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] h;
  } vars_t;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [DIGEST_W-1:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] big_s0(input logic [WORD_W-1:0] x);
    big_s0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] big_s1(input logic [WORD_W-1:0] x);
    big_s1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] small_s0(input logic [WORD_W-1:0] x);
    small_s0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] small_s1(input logic [WORD_W-1:0] x);
    small_s1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                           input logic [WORD_W-1:0] z);
    ch = (x & y) ^ (~x & z);
  endfunction

  function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                            input logic [WORD_W-1:0] z);
    maj = (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// Sliding 16-word message window; wt is always W[t] for the round being applied.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic [BLOCK_W-1:0] block,
  output logic [WORD_W-1:0]  wt
);

  // win[0] holds W[t], win[15] holds W[t+15]
  logic [0:15][WORD_W-1:0] win;
  logic [WORD_W-1:0]       w_new;

  assign w_new = small_s1(win[14]) + win[9] + small_s0(win[1]) + win[0];
  assign wt    = win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (load) begin
      win <= block;
    end else if (advance) begin
      win <= {win[1:15], w_new};
    end
  end

endmodule

// File: rtl/sha256_roundfnc.sv
// One combinational SHA-256 compression round.
module sha256_roundfnc
  import sha256_pkg::*;
(
  input  logic [DIGEST_W-1:0] vars_cur,
  input  logic [WORD_W-1:0]   kt,
  input  logic [WORD_W-1:0]   wt,
  output logic [DIGEST_W-1:0] vars_next_c
);

  vars_t             v;
  vars_t             n;
  logic [WORD_W-1:0] t1;
  logic [WORD_W-1:0] t2;

  always_comb begin
    v  = vars_t'(vars_cur);
    t1 = v.h + big_s1(v.e) + ch(v.e, v.f, v.g) + kt + wt;
    t2 = big_s0(v.a) + maj(v.a, v.b, v.c);
    n   = v;
    n.a = t1 + t2;
    n.b = v.a;
    n.c = v.b;
    n.d = v.c;
    n.e = v.d + t1;
    n.f = v.e;
    n.g = v.f;
    n.h = v.g;
    vars_next_c = n;
  end

endmodule

// File: rtl/sha256_compress_ctrl.sv
// Iterative SHA-256 compression, one round per clock, valid/ready on both sides.
// SHA256_CHAIN_EN adds in_first and chains blocks from the stored digest.
module sha256_compress_ctrl
  import sha256_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLOCK_W-1:0]  in_block,
`ifdef SHA256_CHAIN_EN
  input  logic                in_first,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIGEST_W-1:0] out_digest,
  output logic                busy
);

  state_t              state_q;
  state_t              state_d;
  logic                accept;
  logic                round_en;
  logic                final_en;
  logic                consume;
  logic [T_W-1:0]      t_q;
  logic [DIGEST_W-1:0] vars_q;
  logic [DIGEST_W-1:0] vars_next_c;
  logic [DIGEST_W-1:0] h_q;
  logic [DIGEST_W-1:0] h_new;
  logic [DIGEST_W-1:0] start_h;
  logic [WORD_W-1:0]   wt;
  logic [WORD_W-1:0]   kt;

`ifdef SHA256_CHAIN_EN
  assign start_h = in_first ? IV : h_q;
`else
  assign start_h = IV;
`endif

  assign kt = K[t_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    round_en = 1'b0;
    final_en = 1'b0;
    consume  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        round_en = 1'b1;
        if (t_q == T_W'(ROUNDS - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        final_en = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          consume = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Feed-forward: add working variables back into the chaining value
  for (genvar i = 0; i < 8; i++) begin : g_add
    assign h_new[i*WORD_W +: WORD_W] = h_q[i*WORD_W +: WORD_W] + vars_q[i*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q        <= '0;
      vars_q     <= '0;
      h_q        <= IV;
      out_valid  <= 1'b0;
      out_digest <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      in_ready <= (state_d == IDLE);
      busy     <= (state_d != IDLE);
      if (accept) begin
        vars_q <= start_h;
        h_q    <= start_h;
        t_q    <= '0;
      end else if (round_en) begin
        vars_q <= vars_next_c;
        t_q    <= t_q + T_W'(1);
      end
      if (final_en) begin
        h_q        <= h_new;
        out_digest <= h_new;
        out_valid  <= 1'b1;
      end
      if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

  sha256_msg_sched u_sched (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .advance (round_en),
    .block   (in_block),
    .wt      (wt)
  );

  sha256_roundfnc u_round (
    .vars_cur    (vars_q),
    .kt          (kt),
    .wt          (wt),
    .vars_next_c (vars_next_c)
  );

endmodule
